// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension pipe: op encodings and op width.
package ext_pkg;

  localparam int EXT_OP_W = 3;

  typedef enum logic [EXT_OP_W-1:0] {
    EXT_SIGN    = 3'b000,
    EXT_ZERO    = 3'b001,
    EXT_UPPER   = 3'b010,
    EXT_SIGN_SH = 3'b011,
    EXT_ZERO_SH = 3'b100
  } ext_op_e;

  // Encodings above EXT_ZERO_SH have no defined extension.
  function automatic logic ext_op_reserved(input logic [EXT_OP_W-1:0] op);
    return (op > EXT_ZERO_SH);
  endfunction

endpackage

// File: rtl/ext_fifo2.sv
// Generic 2-entry in-order buffer; entry 0 is always the head.
module ext_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         wr, rd;

  // A write into a full buffer is only legal when the head leaves the same cycle.
  assign wr = push && ((cnt_q != 2'd2) || pop);
  assign rd = pop && (cnt_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = wdata;
          else               e1_d = wdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = wdata;
          end else begin
            e0_d = e1_q;
            e1_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate-extension unit with a 2-entry output buffer.
// Optional reserved-op counter enabled by defining EXT_ERR_CNT_EN.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_imm,
  input  logic [EXT_OP_W-1:0] in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err,
  output logic [15:0]         err_cnt
);

  generate
    if (OUT_W < IN_W + SHIFT) begin : g_bad_width
      $error("ext_pipe: OUT_W must be >= IN_W + SHIFT");
    end
  endgenerate

  logic signed [IN_W-1:0] imm_s;
  logic [OUT_W-1:0]       sext, zext, ext_data;
  logic                   ext_err;
  logic                   accept, deliver;
  logic [1:0]             count;
  logic [OUT_W:0]         head;

  assign imm_s = $signed(in_imm);
  assign sext  = OUT_W'(imm_s);
  assign zext  = OUT_W'(in_imm);

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_op)
      EXT_SIGN:    ext_data = sext;
      EXT_ZERO:    ext_data = zext;
      EXT_UPPER:   ext_data = zext << (OUT_W - IN_W);
      EXT_SIGN_SH: ext_data = sext << SHIFT;
      EXT_ZERO_SH: ext_data = zext << SHIFT;
      default:     ext_err  = 1'b1;
    endcase
  end

  // in_ready depends on the registered count only, so out_ready never reaches decode.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  ext_fifo2 #(.W(OUT_W + 1)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (accept),
    .pop     (deliver),
    .wdata   ({ext_err, ext_data}),
    .rdata   (head),
    .count   (count)
  );

  assign out_err  = head[OUT_W];
  assign out_data = head[OUT_W-1:0];

`ifdef EXT_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && ext_op_reserved(in_op) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= 16'd0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed literal cases plus randomized traffic
// checked every cycle against a queue-based model of the output buffer.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [32:0] mq[$];
  int          m_errs = 0;

  ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // {err, data} computed with plain arithmetic
  function automatic logic [32:0] model_ext(input logic [15:0] imm, input logic [2:0] op);
    longint s, u, r;
    u = longint'(imm);
    s = imm[15] ? u - 65536 : u;
    case (op)
      3'd0: r = s;
      3'd1: r = u;
      3'd2: r = u * 65536;
      3'd3: r = s * 4;
      3'd4: r = u * 4;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  function automatic int exp_cnt();
`ifdef EXT_ERR_CNT_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model on the rising edge,
  // return at the next falling edge.
  task automatic cycle(input bit v, input logic [15:0] imm, input logic [2:0] op,
                       input bit ordy, input bit fl);
    bit acc, pop;
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    acc = v && (mq.size() < 2);
    pop = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (acc && op >= 3'd5 && m_errs < 65535) m_errs++;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(model_ext(imm, op));
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("in_ready", in_ready, mq.size() < 2);
      check("err_cnt", err_cnt, exp_cnt());
      if (mq.size() != 0) begin
        check("out_data", out_data, mq[0][31:0]);
        check("out_err", out_err, mq[0][32]);
      end
    end
  end

  initial begin
    // model sanity against hand values
    check("model_sext", model_ext(16'h8001, 3'd0), {1'b0, 32'hFFFF8001});
    check("model_zsh", model_ext(16'hFFFF, 3'd4), {1'b0, 32'h0003FFFC});

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    cycle(1, 16'h8001, 3'd0, 0, 0);
    check("op0", out_data, 32'hFFFF8001);
    check("op0_valid", out_valid, 1);
    cycle(1, 16'h8001, 3'd1, 1, 0);
    check("op1", out_data, 32'h00008001);
    cycle(1, 16'h1234, 3'd2, 1, 0);
    check("op2", out_data, 32'h12340000);
    cycle(1, 16'hFFFF, 3'd3, 1, 0);
    check("op3", out_data, 32'hFFFFFFFC);
    cycle(1, 16'hFFFF, 3'd4, 1, 0);
    check("op4", out_data, 32'h0003FFFC);
    cycle(1, 16'h00AA, 3'd6, 1, 0);
    check("op6_data", out_data, 0);
    check("op6_err", out_err, 1);
`ifdef EXT_ERR_CNT_EN
    check("op6_cnt", err_cnt, 1);
`else
    check("op6_cnt", err_cnt, 0);
`endif
    cycle(0, 16'h0, 3'd0, 1, 0);
    check("drained", out_valid, 0);

    // back-pressure: third push refused
    cycle(1, 16'h0001, 3'd1, 0, 0);
    check("bp_ready1", in_ready, 1);
    cycle(1, 16'h0002, 3'd1, 0, 0);
    check("bp_ready0", in_ready, 0);
    cycle(1, 16'h0003, 3'd1, 0, 0);
    check("bp_head", out_data, 32'h1);
    cycle(0, 16'h0, 3'd0, 1, 0);
    check("bp_second", out_data, 32'h2);
    check("bp_ready_back", in_ready, 1);
    cycle(0, 16'h0, 3'd0, 1, 0);
    check("bp_empty", out_valid, 0);

    // streaming at count 1
    cycle(1, 16'h0100, 3'd0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 16'(16'h0200 + i), 3'd1, 1, 0);
      check("stream_data", out_data, 32'h200 + i);
      check("stream_ready", in_ready, 1);
    end
    cycle(0, 16'h0, 3'd0, 1, 0);

    // flush at full with a push attempt
    cycle(1, 16'h0011, 3'd1, 0, 0);
    cycle(1, 16'h0022, 3'd1, 0, 0);
    cycle(1, 16'h0033, 3'd1, 0, 1);
    check("flush_valid", out_valid, 0);
    cycle(0, 16'h0, 3'd0, 1, 0);
    check("flush_lost", out_valid, 0);

    // flush at count 1 with push and pop
    cycle(1, 16'h0044, 3'd1, 0, 0);
    cycle(1, 16'h0055, 3'd1, 1, 1);
    check("flush1_valid", out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), 16'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    // asynchronous reset mid-stream
    cycle(1, 16'h7777, 3'd0, 0, 0);
    cycle(1, 16'h8888, 3'd0, 0, 0);
    #2;
    reset_n = 1'b0;
    mq.delete();
    m_errs = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_err", out_err, 0);
    check("arst_ready", in_ready, 1);
    check("arst_cnt", err_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 16'h0, 3'd0, 1, 0);
    check("arst_no_output", out_valid, 0);
    cycle(1, 16'h0005, 3'd3, 1, 0);
    check("arst_new", out_data, 32'h14);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
